// File: rtl/packet_enhancer_fifo.sv
// Show-ahead packet FIFO that tags each accepted packet with a priority and a
// parity-error flag, and keeps a saturating count of errored packets.
module packet_enhancer_fifo #(
  parameter int ID_W   = 4,
  parameter int DATA_W = 8,
  parameter int PRIO_W = 2,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ID_W-1:0]            in_id,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_parity,
  input  logic [ID_W-1:0]            cfg_hi_id,
  input  logic [PRIO_W-1:0]          cfg_prio_default,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ID_W-1:0]            out_id,
  output logic [DATA_W-1:0]          out_data,
  output logic [PRIO_W-1:0]          out_priority,
  output logic                       out_error,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [CNT_W-1:0]           err_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int E_W   = ID_W + DATA_W + PRIO_W + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [E_W-1:0]    mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CW-1:0]     count_reg;
  logic [CNT_W-1:0]  err_count_reg;

  logic              wr_en;
  logic              rd_en;
  logic              in_err;
  logic [PRIO_W-1:0] in_prio;
  logic [E_W-1:0]    head;

  // Handshake flags come only from registered occupancy, never from the inputs.
  assign in_ready  = (count_reg != FULL);
  assign out_valid = (count_reg != '0);
  assign wr_en     = in_valid && in_ready;
  assign rd_en     = out_valid && out_ready;

  assign in_err  = ((^in_data) != in_parity);
  assign in_prio = (in_id == cfg_hi_id) ? {PRIO_W{1'b1}} : cfg_prio_default;

  assign head = out_valid ? mem[rd_ptr_reg] : '0;
  assign {out_id, out_data, out_priority, out_error} = head;

  assign count     = count_reg;
  assign err_count = err_count_reg;

  // Storage holds no reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[wr_ptr_reg] <= {in_id, in_data, in_prio, in_err};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      err_count_reg <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (rd_en) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (wr_en && in_err && (err_count_reg != {CNT_W{1'b1}})) begin
        err_count_reg <= err_count_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_packet_enhancer_fifo.sv
// Bench for packet_enhancer_fifo: vector table plus hand sequences, with a
// queue holding the entries the FIFO is expected to present, in order.
module tb_packet_enhancer_fifo;

  localparam int ID_W   = 4;
  localparam int DATA_W = 8;
  localparam int PRIO_W = 2;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 2;
  localparam int CW     = $clog2(DEPTH + 1);

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [ID_W-1:0]   in_id;
  logic [DATA_W-1:0] in_data;
  logic              in_parity;
  logic [ID_W-1:0]   cfg_hi_id;
  logic [PRIO_W-1:0] cfg_prio_default;
  logic              out_valid;
  logic              out_ready;
  logic [ID_W-1:0]   out_id;
  logic [DATA_W-1:0] out_data;
  logic [PRIO_W-1:0] out_priority;
  logic              out_error;
  logic [CW-1:0]     count;
  logic [CNT_W-1:0]  err_count;

  packet_enhancer_fifo #(
    .ID_W(ID_W), .DATA_W(DATA_W), .PRIO_W(PRIO_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_id(in_id), .in_data(in_data), .in_parity(in_parity),
    .cfg_hi_id(cfg_hi_id), .cfg_prio_default(cfg_prio_default),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_id(out_id), .out_data(out_data), .out_priority(out_priority),
    .out_error(out_error), .count(count), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [PRIO_W-1:0] prio;
    logic              err;
  } ent_t;

  typedef struct {
    logic              v;
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] d;
    logic              p;
    logic              r;
    logic [ID_W-1:0]   hi;
    logic [PRIO_W-1:0] pdef;
    logic [PRIO_W-1:0] ep;
    logic              ee;
  } vec_t;

  ent_t              sb[$];
  int                n_cmp = 0;
  int                n_bad = 0;
  int                exp_err = 0;
  logic [ID_W-1:0]   cfg_hi = '0;
  logic [PRIO_W-1:0] cfg_def = '0;
  vec_t              vecs[8];
  int                sat_exp[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive at #1 after the edge, check at the falling edge, update model.
  task automatic cycle(input logic v, input logic [ID_W-1:0] id, input logic [DATA_W-1:0] d,
                       input logic p, input logic r, input logic [PRIO_W-1:0] ep, input logic ee);
    ent_t e;
    bit   in_fire;
    bit   out_fire;
    in_valid = v; in_id = id; in_data = d; in_parity = p; out_ready = r;
    cfg_hi_id = cfg_hi; cfg_prio_default = cfg_def;
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(sb.size() != DEPTH));
    chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    chk("count", 32'(count), 32'(sb.size()));
    chk("err_count", 32'(err_count), 32'(exp_err));
    if (sb.size() != 0)
      chk("head", 32'({out_id, out_data, out_priority, out_error}), 32'(sb[0]));
    else
      chk("idle_zero", 32'({out_id, out_data, out_priority, out_error}), 32'd0);
    in_fire  = v && (sb.size() != DEPTH);
    out_fire = r && (sb.size() != 0);
    if (out_fire) begin
      e = sb.pop_front();
      $display("out: id=%h data=%h prio=%0d err=%0b", e.id, e.data, e.prio, e.err);
    end
    if (in_fire) begin
      e = '{id: id, data: d, prio: ep, err: ee};
      sb.push_back(e);
      if (ee && exp_err != (1 << CNT_W) - 1) exp_err++;
      $display("in:  id=%h data=%h prio=%0d err=%0b", id, d, ep, ee);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic v, input logic [ID_W-1:0] id, input logic [DATA_W-1:0] d,
                      input logic p, input logic r);
    cycle(v, id, d, p, r, (id == cfg_hi) ? {PRIO_W{1'b1}} : cfg_def, ((^d) != p));
  endtask

  initial begin
    vecs[0] = '{1'b1, 4'h5, 8'hAA, 1'b0, 1'b0, 4'h5, 2'd1, 2'd3, 1'b0};
    vecs[1] = '{1'b1, 4'h2, 8'h01, 1'b0, 1'b1, 4'h5, 2'd1, 2'd1, 1'b1};
    vecs[2] = '{1'b1, 4'h3, 8'h03, 1'b0, 1'b1, 4'h3, 2'd0, 2'd3, 1'b0};
    vecs[3] = '{1'b1, 4'h7, 8'h80, 1'b1, 1'b1, 4'h3, 2'd2, 2'd2, 1'b0};
    vecs[4] = '{1'b1, 4'h0, 8'hFF, 1'b1, 1'b1, 4'h0, 2'd1, 2'd3, 1'b1};
    vecs[5] = '{1'b1, 4'hF, 8'h7F, 1'b1, 1'b0, 4'hE, 2'd0, 2'd0, 1'b0};
    vecs[6] = '{1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 4'hE, 2'd0, 2'd0, 1'b0};
    vecs[7] = '{1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 4'hE, 2'd0, 2'd0, 1'b0};
    sat_exp = '{1, 2, 3, 3, 3};

    // Reset with handshakes offered: all must be ignored.
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_id = 4'h1; in_data = 8'h11;
    in_parity = 1'b0; cfg_hi_id = '0; cfg_prio_default = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_fields", 32'({out_id, out_data, out_priority, out_error}), 32'd0);
    rst = 1'b0;

    // Vector table: priority promotion, default priority, parity errors.
    for (int i = 0; i < 8; i++) begin
      cfg_hi  = vecs[i].hi;
      cfg_def = vecs[i].pdef;
      cycle(vecs[i].v, vecs[i].id, vecs[i].d, vecs[i].p, vecs[i].r, vecs[i].ep, vecs[i].ee);
    end
    chk("table_drained", 32'(count), 32'd0);

    // Fill with consumer stalled; the extra push must be refused.
    cfg_hi = 4'hA; cfg_def = 2'd2;
    for (int i = 0; i <= DEPTH; i++) begin
      send(1'b1, 4'(i + 8), 8'(i * 37 + 5), 1'b0, 1'b0);
    end
    chk("full_count", 32'(count), 32'(DEPTH));
    chk("full_in_ready", 32'(in_ready), 32'd0);
    send(1'b1, 4'hC, 8'hCC, 1'b0, 1'b1);
    chk("full_no_write", 32'(count), 32'(DEPTH - 1));
    for (int i = 0; i < DEPTH; i++) send(1'b0, 4'h0, 8'h00, 1'b0, 1'b1);
    chk("drain_count", 32'(count), 32'd0);
    send(1'b0, 4'h0, 8'h00, 1'b0, 1'b1);

    // Streaming across several pointer wraps.
    cfg_hi = 4'hF; cfg_def = 2'd1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      send(1'b1, 4'(i), 8'(8'h10 + i), ^(8'(8'h10 + i)), 1'b1);
      chk("stream_count", 32'(count), 32'd1);
    end
    send(1'b0, 4'h0, 8'h00, 1'b0, 1'b1);
    chk("stream_drained", 32'(count), 32'd0);

    // Saturation of the error counter from a clean start.
    rst = 1'b1; #2; rst = 1'b0;
    sb.delete(); exp_err = 0;
    for (int i = 0; i < 5; i++) begin
      send(1'b1, 4'(i), 8'h01, 1'b0, 1'b1);
      chk("sat_err_count", 32'(err_count), 32'(sat_exp[i]));
    end
    send(1'b0, 4'h0, 8'h00, 1'b0, 1'b1);

    // Reset between edges with three entries stored.
    rst = 1'b1; #2; rst = 1'b0;
    sb.delete(); exp_err = 0;
    for (int i = 0; i < 3; i++) send(1'b1, 4'(i + 1), 8'(8'h20 + i), 1'b0, 1'b0);
    chk("pre_rst_count", 32'(count), 32'd3);
    rst = 1'b1; in_valid = 1'b1;
    #2;
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_count", 32'(count), 32'd0);
    chk("async_in_ready", 32'(in_ready), 32'd1);
    chk("async_fields", 32'({out_id, out_data, out_priority, out_error}), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hs_ignored", 32'(count), 32'd0);
    rst = 1'b0;
    sb.delete(); exp_err = 0;
    send(1'b1, 4'h9, 8'h5A, 1'b0, 1'b0);
    send(1'b0, 4'h0, 8'h00, 1'b0, 1'b1);
    send(1'b0, 4'h0, 8'h00, 1'b0, 1'b1);
    chk("final_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/packet_enhancer_fifo.md
PACKET_ENHANCER_FIFO -- requirements
Module: packet_enhancer_fifo

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- ID_W, 4, packet id width.
- DATA_W, 8, packet data width.
- PRIO_W, 2, priority field width.
- DEPTH, 4, FIFO entries; power of two, >=2.
- CNT_W, 8, error counter width.

REQ-002 The block SHALL have one clock; reset is asynchronous and active-high.

REQ-003 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk, in, 1, clock, rising edge.
- rst, in, 1, asynchronous active-high reset.
- in_valid, in, 1, input packet valid.
- in_ready, out, 1, FIFO can accept.
- in_id, in, ID_W, packet id.
- in_data, in, DATA_W, packet data.
- in_parity, in, 1, sender even parity of in_data.
- cfg_hi_id, in, ID_W, id that is promoted to top priority.
- cfg_prio_default, in, PRIO_W, priority for all other ids.
- out_valid, out, 1, head entry valid.
- out_ready, in, 1, consumer accepts.
- out_id, out, ID_W, head id.
- out_data, out, DATA_W, head data.
- out_priority, out, PRIO_W, head priority.
- out_error, out, 1, head parity-error flag.
- count, out, $clog2(DEPTH+1), occupied entries.
- err_count, out, CNT_W, saturating count of accepted errored packets.

Function
REQ-004 An input transfer SHALL occur in a cycle with in_valid=1 and in_ready=1; an output transfer SHALL occur in a cycle with out_valid=1 and out_ready=1.

REQ-005 The block SHALL drive in_ready = (count != DEPTH) and out_valid = (count != 0), both taken from registered state only.

REQ-006 On an input transfer the block SHALL write one entry {in_id, in_data, priority, error} at the write pointer.
- priority = all-ones when in_id == cfg_hi_id, else cfg_prio_default.
- error = (XOR-reduce of in_data) != in_parity.
- cfg_* values are sampled in the transfer cycle.

REQ-007 The FIFO SHALL be show-ahead: out_id/out_data/out_priority/out_error present the head entry whenever out_valid=1.

REQ-008 out_id, out_data, out_priority and out_error SHALL be driven to 0 whenever out_valid=0.

REQ-009 Latency SHALL be exactly one cycle:
- a packet accepted into an empty FIFO at edge N is presented with out_valid=1 after edge N;
- there is no combinational input-to-output bypass.

REQ-010 Pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0 with no gap.

REQ-011 On a simultaneous input and output transfer, count SHALL be unchanged and both pointers SHALL advance. This is legal at any occupancy in 1..DEPTH-1.

REQ-012 When full, in_ready=0, so no write SHALL occur even if out_ready=1 in the same cycle; a slot frees on the next cycle.

REQ-013 When empty, out_ready SHALL be ignored and no pointer SHALL move.

REQ-014 On each input transfer with error=1, err_count SHALL increment by 1 and hold at 2^CNT_W-1 (saturate, no wrap).

REQ-015 The FIFO SHALL never overflow or underflow. Entry ordering SHALL be strict first in, first out.

Reset
REQ-016 While rst=1, the following SHALL hold:
- count=0, pointers=0, err_count=0;
- out_valid=0 and all out_* fields 0;
- in_ready=1;
- any handshakes in these cycles are ignored.

REQ-017 Reset asserted mid-operation SHALL discard all stored entries immediately (asynchronously). The first accepted packet after release SHALL be the first presented.

REQ-018 Storage array contents SHALL need no reset; only pointers, count and err_count are reset.

Verification
REQ-019 Single packet: cfg_hi_id=5, cfg_prio_default=1, send id=5, data=0xAA, parity=0 -> next cycle out_valid=1, id=5, data=0xAA, priority=3, error=0.

REQ-020 Parity error: send id=2, data=0x01, parity=0 -> out_priority=1, out_error=1, err_count=1.

REQ-021 Fill/drain: hold out_ready=0 and push DEPTH packets -> in_ready=0 and count=DEPTH. A further in_valid is not accepted. Then drain -> all DEPTH packets emerge in order and count returns to 0.

REQ-022 Streaming with wrap: in_valid=out_ready=1 for 3*DEPTH consecutive cycles with incrementing data -> count steady at 1, no data lost or reordered across pointer wrap.

REQ-023 Saturation: with CNT_W=2, push 5 errored packets -> err_count reads 1,2,3,3,3.

REQ-024 Reset mid-stream: with 3 entries stored, pulse rst between edges -> out_valid=0, count=0 immediately. The next pushed packet is the first output.
